// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 width/sign codes,
// load/store unit FSM encodings, and request legality helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lsu_state_t;

  // Stores only have signed-less B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = offset[0];
      F3_W:        bad = (offset != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational; the caller decides when the results are sampled.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: replicate narrow data across lanes so any lane can be enabled.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_offset;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << st_offset;
      end
      default: ;
    endcase
  end

  // Load: pick the addressed lane, then sign- or zero-extend to 32 bits.
  always_comb begin
    ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one request at a time, drives a
// req/ready data port, aborts on a bus timeout and produces a one-cycle
// register-file writeback for loads.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        access_fault,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Value held during the last REQ cycle allowed before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t state_reg, state_next;

  logic             op_store_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       offset_reg;
  logic [4:0]       rd_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       wb_rd_reg;
  logic [31:0]      wb_data_reg;
  logic             misaligned_reg;
  logic             fault_reg;

  logic        req_legal;
  logic        req_misaligned;
  logic        accept;
  logic        timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;

  assign req_legal      = f3_legal(op_store, funct3);
  assign req_misaligned = f3_misaligned(funct3, addr[1:0]);
  assign accept         = (state_reg == ST_IDLE) && start && req_legal && !req_misaligned;
  assign timeout_hit    = (state_reg == ST_REQ) && !mem_ready && (cnt_reg == CNT_LAST);

  // Store steering uses the live request; load extraction uses the latched one.
  lsu_align u_align (
    .st_funct3 (funct3),
    .st_offset (addr[1:0]),
    .st_data   (store_data),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (funct3_reg),
    .ld_offset (offset_reg),
    .ld_rdata  (mem_rdata),
    .ld_data   (ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a ready on the final allowed cycle beats the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ: begin
        if (mem_ready)        state_next = ST_WB;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    busy    = (state_reg != ST_IDLE);
    mem_req = (state_reg == ST_REQ);
    mem_we  = (state_reg == ST_REQ) && op_store_reg;
    done    = (state_reg == ST_WB);
    wb_we   = (state_reg == ST_WB) && !op_store_reg && (rd_reg != 5'd0);
  end

  // Request latches, timeout counter, writeback capture and fault pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_store_reg   <= 1'b0;
      funct3_reg     <= 3'b000;
      offset_reg     <= 2'b00;
      rd_reg         <= 5'd0;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      wstrb_reg      <= 4'h0;
      cnt_reg        <= '0;
      wb_rd_reg      <= 5'd0;
      wb_data_reg    <= 32'h0;
      misaligned_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      misaligned_reg <= (state_reg == ST_IDLE) && start && req_legal && req_misaligned;
      fault_reg      <= ((state_reg == ST_IDLE) && start && !req_legal) || timeout_hit;
      if (accept) begin
        op_store_reg <= op_store;
        funct3_reg   <= funct3;
        offset_reg   <= addr[1:0];
        rd_reg       <= rd;
        addr_reg     <= {addr[31:2], 2'b00};
        wdata_reg    <= st_wdata;
        wstrb_reg    <= op_store ? st_wstrb : 4'h0;
        cnt_reg      <= '0;
      end
      if ((state_reg == ST_REQ) && !mem_ready) cnt_reg <= cnt_reg + 1'b1;
      if ((state_reg == ST_REQ) && mem_ready && !op_store_reg) begin
        wb_rd_reg   <= rd_reg;
        wb_data_reg <= ld_data;
      end
    end
  end

  assign misaligned   = misaligned_reg;
  assign access_fault = fault_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_wstrb    = wstrb_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes reference-model
// expectations, a monitor checks memory-port and completion behaviour.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy, done, misaligned, access_fault, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_waits = 0;
  logic [31:0] cur_rdata = 32'h0;
  bit skip_mem = 1'b0;

  typedef struct {
    logic [2:0]  kind;   // {done, misaligned, access_fault}
    int          cyc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mem;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mstrb;
  } exp_t;

  exp_t exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .op_store(op_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd(rd), .busy(busy), .done(done),
    .misaligned(misaligned), .access_fault(access_fault), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: access size from funct3, lanes from byte-address arithmetic.
  function automatic exp_t model(input bit op, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] sd, input bit [4:0] r, input int waits,
                                 input bit [31:0] rdat, input int c);
    exp_t e;
    int size, off;
    bit legal;
    logic [63:0] raw, mask;
    e = '{default: '0};
    off = int'(a % 4);
    size = 1 << (f3 % 4);
    legal = op ? (f3 <= 2) : (f3 != 3 && f3 != 6 && f3 != 7);
    if (!legal) begin
      e.kind = 3'b001; e.cyc = c + 1; return e;
    end
    if ((a % size) != 0) begin
      e.kind = 3'b010; e.cyc = c + 1; return e;
    end
    e.mem   = 1'b1;
    e.mwe   = op;
    e.maddr = a - off;
    e.mstrb = op ? 4'(((1 << size) - 1) << off) : 4'h0;
    e.mwdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
    if (waits >= TMO) begin
      e.kind = 3'b001; e.cyc = c + 1 + TMO; return e;
    end
    e.kind = 3'b100;
    e.cyc  = c + 2 + waits;
    e.we   = !op && (r != 0);
    e.rd   = r;
    mask = (64'h1 << (8 * size)) - 1;
    raw  = ({32'h0, rdat} >> (8 * off)) & mask;
    if (f3 < 4 && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
    e.data = raw[31:0];
    return e;
  endfunction

  // Memory responder: ready after cur_waits stall cycles, garbage data otherwise.
  initial begin
    int req_cnt;
    req_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && req_cnt == cur_waits) begin
        mem_ready = 1'b1; mem_rdata = cur_rdata;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      if (mem_req && !rst) req_cnt++;
      else req_cnt = 0;
    end
  end

  // Monitor: memory-port contents while requesting, and completion pulses.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && !skip_mem) begin
          if (exp_q.size() == 0) chk("mem_req_unexpected", 32'(mem_req), 32'd0);
          else begin
            h = exp_q[0];
            chk("mem_req_allowed", 32'(h.mem), 32'd1);
            if (h.mem) begin
              chk("mem_we", 32'(mem_we), 32'(h.mwe));
              chk("mem_addr", mem_addr, h.maddr);
              chk("mem_wstrb", 32'(mem_wstrb), 32'(h.mstrb));
              if (h.mwe) chk("mem_wdata", mem_wdata, h.mwdata);
            end
          end
        end
        if (!done) chk("wb_we_outside_wb", 32'(wb_we), 32'd0);
        if (done || misaligned || access_fault) begin
          if (exp_q.size() == 0)
            chk("unexpected_response", 32'({done, misaligned, access_fault}), 32'd0);
          else begin
            h = exp_q.pop_front();
            chk("response_kind", 32'({done, misaligned, access_fault}), 32'(h.kind));
            chk("response_cycle", 32'(cyc), 32'(h.cyc));
            if (done) begin
              chk("wb_we", 32'(wb_we), 32'(h.we));
              if (h.we) begin
                chk("wb_rd", 32'(wb_rd), 32'(h.rd));
                chk("wb_data", wb_data, h.data);
              end
            end
          end
        end
      end
    end
  end

  // One request; random start pulses while busy must be ignored.
  task automatic issue(input bit op, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd,
                       input bit [4:0] r, input int waits, input bit [31:0] rdat);
    int n;
    cur_waits = waits;
    cur_rdata = rdat;
    exp_q.push_back(model(op, f3, a, sd, r, waits, rdat, cyc));
    $display("txn op_store=%0d funct3=%0d addr=%h data=%h rd=%0d waits=%0d rdata=%h",
             op, f3, a, sd, r, waits, rdat);
    op_store = op; funct3 = f3; addr = a; store_data = sd; rd = r; start = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; op_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 2));
        addr = $urandom & 32'hFFFF_FFFC; store_data = $urandom; rd = 5'($urandom_range(1, 31));
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("response_within_bound", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit op;
    bit [2:0] f3;
    int w;
    rst = 1'b1; start = 1'b0; op_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; rd = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'({done, misaligned, access_fault, wb_we}), 32'd0);
    chk("reset_wb", {27'h0, wb_rd} | wb_data, 32'd0);
    chk("reset_mem_ctl", 32'({mem_req, mem_we, mem_wstrb}), 32'd0);
    chk("reset_mem_data", mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 32'h80FF1234);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h80FF1234);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 0, 32'h80FF1234);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 0, 32'h80FF1234);
    issue(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 5'd3, 2, 32'h0);
    issue(1'b1, 3'b000, 32'h41, 32'h123456A5, 5'd3, 0, 32'h0);
    issue(1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 5'd3, 1, 32'h0);
    issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd5, 0, 32'h1);
    issue(1'b0, 3'b001, 32'h103, 32'h0, 5'd5, 0, 32'h1);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd5, 0, 32'h1);
    issue(1'b1, 3'b100, 32'h101, 32'h0, 5'd5, 0, 32'h1);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 100, 32'h1);
    issue(1'b0, 3'b010, 32'h204, 32'h0, 5'd4, TMO - 1, 32'h55AA55AA);
    issue(1'b0, 3'b010, 32'h208, 32'h0, 5'd0, 0, 32'h12345678);

    // Reset during REQ abandons the operation silently.
    $display("txn reset during REQ");
    cur_waits = 1000; skip_mem = 1'b1;
    op_store = 1'b0; funct3 = 3'b010; addr = 32'h300; rd = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req_busy", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_mem_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    skip_mem = 1'b0;
    issue(1'b0, 3'b000, 32'h305, 32'h0, 5'd11, 0, 32'h00007F00);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (op) f3 = 3'($urandom_range(0, 2));
      else begin
        w = $urandom_range(0, 4);
        f3 = (w < 3) ? 3'(w) : 3'(w + 1);
      end
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      issue(op, f3, $urandom, $urandom, 5'($urandom_range(0, 31)), w, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
